// File: rtl/core_pkg.sv
// Shared core definitions: register-file geometry and register index type.
package core_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;

  typedef logic [AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

endpackage : core_pkg

// File: rtl/sb_counter.sv
// Per-register in-flight write counter for the register scoreboard.
// Saturating up/down counter with synchronous clear; nz is registered from
// the next-state count so it reflects the count after each edge.
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             dec,
  input  logic             clr,
  output logic [CNT_W-1:0] cnt,
  output logic             nz
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAXC = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             nz_q, nz_d;

  // Next count: clear wins; otherwise one increment and one decrement cancel,
  // decrement never underflows and increment never wraps.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = ZERO;
    end else if (inc && !(dec && (cnt_q != ZERO))) begin
      if (cnt_q != MAXC) begin
        cnt_d = cnt_q + ONE;
      end else begin
        cnt_d = cnt_q;
      end
    end else if (!inc && dec && (cnt_q != ZERO)) begin
      cnt_d = cnt_q - ONE;
    end else begin
      cnt_d = cnt_q;
    end
    nz_d = (cnt_d != ZERO);
  end

  // Counter and busy flag state, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= ZERO;
      nz_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      nz_q  <= nz_d;
    end
  end

  assign cnt = cnt_q;
  assign nz  = nz_q;

endmodule : sb_counter

// File: rtl/reg_scoreboard.sv
// Read-side hazard tracker for the 32-entry register file. Counts in-flight
// writes per register, stalls issue on RAW hazards or a saturated destination
// count, and releases entries in the same cycle writeback writes the file.
module reg_scoreboard
  import core_pkg::*;
#(
  parameter int CNT_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rs1,
  input  logic            issue_rs1_used,
  input  logic [AW-1:0]   issue_rs2,
  input  logic            issue_rs2_used,
  input  logic [AW-1:0]   issue_rd,
  input  logic            issue_rd_we,
  output logic            stall,
  input  logic            wb_valid,
  input  logic [AW-1:0]   wb_rd,
  input  logic            flush,
  output logic [NREG-1:0] busy_vec,
  output logic            err
);

  localparam logic [CNT_W-1:0] ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAXC = {CNT_W{1'b1}};

  logic [CNT_W-1:0] cnt_s [NREG];
  logic [CNT_W-1:0] eff_s [NREG];
  logic [NREG-1:0]  nz_s;
  logic             haz1_s, haz2_s, sat_s, stall_s, acc_s;
  logic             err_q, err_d;

  // x0 is never tracked: constant zero count and never busy.
  assign cnt_s[0] = ZERO;
  assign eff_s[0] = ZERO;
  assign nz_s[0]  = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_reg
    logic rel_g, inc_g;

    // Writeback release and accepted-issue increment for this register.
    assign rel_g = wb_valid && (wb_rd == reg_idx_t'(g));
    assign inc_g = acc_s && issue_rd_we && (issue_rd == reg_idx_t'(g));

    // Effective count seen by issue: a same-cycle writeback is already gone.
    assign eff_s[g] = (rel_g && (cnt_s[g] != ZERO)) ? (cnt_s[g] - ONE) : cnt_s[g];

    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (inc_g),
      .dec   (rel_g),
      .clr   (flush),
      .cnt   (cnt_s[g]),
      .nz    (nz_s[g])
    );
  end

  // Hazard decode against the bypassed counts; flush suppresses the stall.
  always_comb begin
    haz1_s  = issue_rs1_used && (issue_rs1 != REG_ZERO) && (eff_s[issue_rs1] != ZERO);
    haz2_s  = issue_rs2_used && (issue_rs2 != REG_ZERO) && (eff_s[issue_rs2] != ZERO);
    sat_s   = issue_rd_we && (issue_rd != REG_ZERO) && (eff_s[issue_rd] == MAXC);
    stall_s = issue_valid && !flush && (haz1_s || haz2_s || sat_s);
    acc_s   = issue_valid && !stall_s && !flush;
  end

  // Sticky error: a writeback to a register with no write in flight.
  always_comb begin
    if (wb_valid && (wb_rd != REG_ZERO) && (cnt_s[wb_rd] == ZERO) && !flush) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Error flag state; only reset clears it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign stall    = stall_s;
  assign busy_vec = nz_s;
  assign err      = err_q;

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: directed scenarios plus randomized
// traffic checked against a per-register pending-write count model.
module tb_reg_scoreboard;
  import core_pkg::*;

  localparam int MAXC = 3;

  logic            clk = 1'b0;
  logic            reset;
  logic            issue_valid, issue_rs1_used, issue_rs2_used, issue_rd_we;
  logic [AW-1:0]   issue_rs1, issue_rs2, issue_rd, wb_rd;
  logic            wb_valid, flush, stall, err;
  logic [NREG-1:0] busy_vec;

  int checks = 0;
  int errors = 0;
  int cnt_m [NREG];
  bit err_m;
  bit obs_stall, exp_stall;

  reg_scoreboard dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs1_used(issue_rs1_used),
    .issue_rs2(issue_rs2), .issue_rs2_used(issue_rs2_used),
    .issue_rd(issue_rd), .issue_rd_we(issue_rd_we), .stall(stall),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_vec(busy_vec), .err(err)
  );

  always #5 clk = ~clk;

  // Pending writes to r as seen this cycle, after a same-cycle writeback.
  function automatic int eff_m(int r);
    if (r == 0) return 0;
    if (wb_valid && (int'(wb_rd) == r) && cnt_m[r] > 0) return cnt_m[r] - 1;
    return cnt_m[r];
  endfunction

  function automatic bit model_stall();
    if (!issue_valid || flush) return 1'b0;
    if (issue_rs1_used && eff_m(int'(issue_rs1)) != 0) return 1'b1;
    if (issue_rs2_used && eff_m(int'(issue_rs2)) != 0) return 1'b1;
    if (issue_rd_we && issue_rd != 0 && eff_m(int'(issue_rd)) == MAXC) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NREG-1:0] model_busy();
    logic [NREG-1:0] b;
    for (int i = 0; i < NREG; i++) b[i] = (cnt_m[i] != 0);
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NREG; i++) cnt_m[i] = 0;
    err_m = 1'b0;
  endtask

  task automatic set_issue(input bit v, input int rs1, input bit u1, input int rs2,
                           input bit u2, input int rd, input bit we);
    issue_valid = v; issue_rs1 = AW'(rs1); issue_rs1_used = u1;
    issue_rs2 = AW'(rs2); issue_rs2_used = u2; issue_rd = AW'(rd); issue_rd_we = we;
  endtask

  task automatic set_wb(input bit v, input int rd);
    wb_valid = v; wb_rd = AW'(rd);
  endtask

  task automatic idle();
    set_issue(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    set_wb(1'b0, 0);
    flush = 1'b0;
  endtask

  // Called at posedge+1: sample stall mid-cycle, advance model and clock.
  task automatic tick();
    int w;
    #3;
    obs_stall = stall;
    exp_stall = model_stall();
    if (flush) begin
      for (int i = 0; i < NREG; i++) cnt_m[i] = 0;
    end else begin
      w = wb_valid ? int'(wb_rd) : 0;
      if (w != 0) begin
        if (cnt_m[w] == 0) err_m = 1'b1;
        else cnt_m[w] = cnt_m[w] - 1;
      end
      if (issue_valid && !exp_stall && issue_rd_we && issue_rd != 0)
        cnt_m[issue_rd] = cnt_m[issue_rd] + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL reset_busy: got %h expected 0", busy_vec); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    #2 reset = 1'b1;
    @(posedge clk); #1;
    set_issue(1'b1, 0, 1'b0, 0, 1'b0, 5, 1'b1);
    tick();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL issue_rd5_stall: got %b expected 0", obs_stall); end
    checks++; if (busy_vec[5] !== 1'b1) begin errors++; $display("FAIL issue_rd5_busy: got %b expected 1", busy_vec[5]); end
    idle();
  endtask

  task automatic test_raw();
    set_issue(1'b1, 5, 1'b1, 0, 1'b0, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL raw_stall: cycle %0d got %b expected 1", k, obs_stall); end
    end
    set_wb(1'b1, 5);
    tick();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL raw_bypass: got %b expected 0", obs_stall); end
    checks++; if (busy_vec[5] !== 1'b0) begin errors++; $display("FAIL raw_release: busy5 got %b expected 0", busy_vec[5]); end
    idle();
  endtask

  task automatic test_waw();
    set_issue(1'b1, 0, 1'b0, 0, 1'b0, 7, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL waw_fill: cycle %0d got %b expected 0", k, obs_stall); end
    end
    tick();
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL waw_sat: got %b expected 1", obs_stall); end
    set_wb(1'b1, 7);
    tick();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL waw_sat_bypass: got %b expected 0", obs_stall); end
    set_wb(1'b0, 0);
    tick();
    checks++; if (obs_stall !== 1'b1) begin errors++; $display("FAIL waw_still3: got %b expected 1", obs_stall); end
    idle();
    set_wb(1'b1, 7);
    for (int k = 0; k < 3; k++) tick();
    checks++; if (busy_vec !== model_busy()) begin errors++; $display("FAIL waw_drain: got %h expected %h", busy_vec, model_busy()); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL waw_err: got %b expected 0", err); end
    idle();
  endtask

  task automatic test_simul_x0();
    set_issue(1'b1, 0, 1'b0, 0, 1'b0, 9, 1'b1);
    tick();
    set_wb(1'b1, 9);
    tick();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL simul_stall: got %b expected 0", obs_stall); end
    checks++; if (busy_vec[9] !== 1'b1) begin errors++; $display("FAIL simul_busy9: got %b expected 1", busy_vec[9]); end
    set_issue(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    tick();
    checks++; if (busy_vec[9] !== 1'b0) begin errors++; $display("FAIL simul_release9: got %b expected 0", busy_vec[9]); end
    idle();
    set_issue(1'b1, 0, 1'b1, 0, 1'b1, 0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL x0_stall: cycle %0d got %b expected 0", k, obs_stall); end
      checks++; if (busy_vec[0] !== 1'b0) begin errors++; $display("FAIL x0_busy: got %b expected 0", busy_vec[0]); end
    end
    idle();
  endtask

  task automatic test_flush();
    set_issue(1'b1, 0, 1'b0, 0, 1'b0, 3, 1'b1); tick();
    set_issue(1'b1, 0, 1'b0, 0, 1'b0, 4, 1'b1); tick();
    set_issue(1'b1, 0, 1'b0, 0, 1'b0, 31, 1'b1); tick();
    checks++; if (busy_vec !== model_busy()) begin errors++; $display("FAIL flush_pre: got %h expected %h", busy_vec, model_busy()); end
    flush = 1'b1;
    set_issue(1'b1, 3, 1'b1, 4, 1'b1, 31, 1'b1);
    set_wb(1'b1, 3);
    tick();
    checks++; if (obs_stall !== 1'b0) begin errors++; $display("FAIL flush_stall: got %b expected 0", obs_stall); end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL flush_busy: got %h expected 0", busy_vec); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL flush_err: got %b expected 0", err); end
    idle();
  endtask

  task automatic test_error_async();
    set_wb(1'b1, 12);
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_set: got %b expected 1", err); end
    idle();
    set_issue(1'b1, 0, 1'b0, 0, 1'b0, 6, 1'b1);
    tick();
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    set_issue(1'b1, 6, 1'b1, 0, 1'b0, 0, 1'b0);
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL async_pre_stall: got %b expected 1", stall); end
    reset = 1'b0;
    #1;
    model_clear();
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL async_err: got %b expected 0", err); end
    checks++; if (busy_vec !== '0) begin errors++; $display("FAIL async_busy: got %h expected 0", busy_vec); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL async_stall: got %b expected 0", stall); end
    idle();
    #1 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int pend;
    for (int n = 0; n < 400; n++) begin
      set_issue($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                $urandom_range(0, 7), $urandom_range(0, 3) != 0);
      pend = 0;
      for (int r = 1; r < 8; r++) if (cnt_m[r] != 0) pend = r;
      if (pend != 0 && $urandom_range(0, 9) < 7) set_wb($urandom_range(0, 1) == 1, pend);
      else set_wb($urandom_range(0, 7) == 0, $urandom_range(0, 7));
      flush = ($urandom_range(0, 29) == 0);
      tick();
      checks++; if (obs_stall !== exp_stall) begin errors++; $display("FAIL rnd_stall: cycle %0d got %b expected %b", n, obs_stall, exp_stall); end
      checks++; if (busy_vec !== model_busy()) begin errors++; $display("FAIL rnd_busy: cycle %0d got %h expected %h", n, busy_vec, model_busy()); end
      checks++; if (err !== err_m) begin errors++; $display("FAIL rnd_err: cycle %0d got %b expected %b", n, err, err_m); end
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_raw();
    test_waw();
    test_simul_x0();
    test_flush();
    test_error_async();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_reg_scoreboard

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Read-side hazard tracker for the pipelined RISC-V core's 32x32 register file.
- Counts in-flight writes per architectural register. Stalls an issuing instruction whose source registers are still pending, or whose destination's in-flight count is saturated.
- Writeback releases entries in the same cycle the register file accepts the write. The register file writes on the falling edge, so a value released in cycle N is readable in cycle N.
- Sits between decode/issue and writeback.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hardwired zero and never tracked.
- AW, 5, register index width (log2 NREG).
- CNT_W, 2, per-register in-flight counter width; maximum outstanding writes per register is MAXC = 2^CNT_W - 1.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  reset, asynchronous, active-low.
- issue_valid  input  1  decode presents an instruction this cycle.
- issue_rs1  input  AW  source 1 index (instr[19:15]).
- issue_rs1_used  input  1  instruction reads rs1.
- issue_rs2  input  AW  source 2 index (instr[24:20]).
- issue_rs2_used  input  1  instruction reads rs2.
- issue_rd  input  AW  destination index (instr[11:7]).
- issue_rd_we  input  1  instruction writes rd.
- stall  output  1  combinational; issue must hold and re-present the same instruction.
- wb_valid  input  1  writeback performs a register-file write this cycle.
- wb_rd  input  AW  writeback destination index.
- flush  input  1  synchronous pipeline flush; discards all pending state.
- busy_vec  output  NREG  registered; bit i = 1 when cnt[i] != 0; bit 0 is always 0.
- err  output  1  registered, sticky; set on writeback to a register with cnt == 0 (index != 0).

Behaviour:
- State: cnt[1..NREG-1], each CNT_W bits; err flop.
- Reset (asynchronous, reset = 0): all cnt = 0, busy_vec = 0, err = 0. Reset may arrive mid-operation; all pending state is discarded immediately.
- rel[i] = wb_valid & (wb_rd == i) & (i != 0).
- eff[i] = cnt[i] - rel[i], saturating at 0. This is the same-cycle bypass: a writeback releasing a source clears the hazard in that same cycle.
- haz1 = issue_rs1_used & (issue_rs1 != 0) & (eff[issue_rs1] != 0). haz2 is identical for rs2.
- sat = issue_rd_we & (issue_rd != 0) & (eff[issue_rd] == MAXC).
- stall = issue_valid & ~flush & (haz1 | haz2 | sat). stall is 0 whenever issue_valid = 0.
- acc = issue_valid & ~stall & ~flush.
- inc[i] = acc & issue_rd_we & (issue_rd == i) & (i != 0).
- Rising-edge update, in priority order:
  - flush = 1: all cnt = 0, regardless of issue or wb.
  - Otherwise: cnt[i] <= cnt[i] + inc[i] - (rel[i] & (cnt[i] != 0)).
- Simultaneous inc and rel on the same register: net count unchanged.
- Writes and issues to register 0 are ignored; x0 never stalls.
- WAW: a second write to a pending rd is allowed up to MAXC outstanding. Writebacks are in order, so the count alone suffices.
- err: set when wb_valid & wb_rd != 0 & cnt[wb_rd] == 0 & ~flush. That register's cnt stays 0 (no underflow). err is cleared only by reset.
- busy_vec is recomputed from next-state cnt and registered: it reflects state after the edge, with one cycle of latency relative to stall.
- No internal FSM beyond the counters. Throughput is one issue and one writeback per cycle.

Decomposition:
- Shared package (core_pkg): NREG, AW, register-index typedef, REG_ZERO constant. CNT_W stays a local parameter.
- Sub-module sb_counter: one per-register saturating up/down counter (inputs inc, dec, clr; outputs cnt, nz). Instantiated NREG-1 times in a generate loop. The top level holds the decode, hazard compare and err logic.

Test Plan:
- Reset then idle: reset low for 2 cycles -> busy_vec = 0, err = 0, stall = 0. Issue rd = 5 with rd_we = 1 -> next cycle busy_vec[5] = 1.
- RAW stall then release: rd = 5 pending; issue rs1 = 5 used -> stall = 1 for every cycle until the cycle with wb_valid = 1, wb_rd = 5, in which stall = 0 (same-cycle bypass); busy_vec[5] = 0 next cycle.
- WAW saturation (CNT_W = 2): issue three writes to rd = 7 -> cnt = 3. Fourth issue to rd = 7 -> stall = 1. Same cycle with wb_rd = 7 -> stall = 0 and cnt remains 3.
- Simultaneous issue and writeback on rd = 9 with cnt = 1 -> cnt stays 1 and busy_vec[9] stays 1. x0 case: rs1 = 0 with rd = 0 pending-writes -> stall never asserts.
- Flush: registers 3, 4 and 31 pending; assert flush together with issue_valid and wb_valid = 1, wb_rd = 3 -> stall = 0, all cnt = 0 next cycle, err stays 0.
- Error and async reset: wb_valid = 1, wb_rd = 12 with cnt = 0 -> err = 1 next cycle and remains 1. Assert reset mid-cycle -> err, busy_vec and all cnt clear immediately, without waiting for a clock edge.
